// File: rtl/vdma_wbuf_scheduler_pkg.sv
// Shared types for the VDMA write-buffer scheduler: FSM encoding, buffer-select width
// and a one-hot helper for building exclusion masks.
package vdma_wbuf_scheduler_pkg;

  localparam int unsigned BUF_SEL_W = 2;
  localparam int unsigned NUM_BUFS  = 4;

  typedef logic [BUF_SEL_W-1:0] buf_sel_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_STOP = 2'd3
  } state_e;

  function automatic logic [NUM_BUFS-1:0] buf_bit(input buf_sel_t b);
    buf_bit    = '0;
    buf_bit[b] = 1'b1;
  endfunction

endpackage

// File: rtl/vdma_wbuf_scheduler_if.sv
// Write-core control and frame-reader handshake seen by the buffer scheduler.
interface vdma_wbuf_scheduler_if #(
  parameter int unsigned AXI4_ADDR_WIDTH = 32,
  parameter int unsigned INDEX_WIDTH     = 8
) ();
  import vdma_wbuf_scheduler_pkg::*;

  logic                       core_ctl_enable;
  logic                       core_ctl_update;
  logic                       core_ctl_busy;
  logic [INDEX_WIDTH-1:0]     core_ctl_index;
  logic [AXI4_ADDR_WIDTH-1:0] core_param_addr;
  logic                       rd_req;
  logic                       rd_valid;
  buf_sel_t                   rd_sel;
  logic [AXI4_ADDR_WIDTH-1:0] rd_addr;

  modport master (
    output core_ctl_enable, core_ctl_update, core_param_addr, rd_valid, rd_sel, rd_addr,
    input  core_ctl_busy, core_ctl_index, rd_req
  );

  modport slave (
    input  core_ctl_enable, core_ctl_update, core_param_addr, rd_valid, rd_sel, rd_addr,
    output core_ctl_busy, core_ctl_index, rd_req
  );
endinterface

// File: rtl/vdma_wbuf_free_sel.sv
// Picks the lowest-numbered buffer whose bit is clear in the exclusion mask.
module vdma_wbuf_free_sel
  import vdma_wbuf_scheduler_pkg::*;
(
  input  logic [NUM_BUFS-1:0] excl_i,
  output buf_sel_t            free_c
);

  always_comb begin
    free_c = '0;
    for (int i = NUM_BUFS - 1; i >= 0; i--) begin
      if (!excl_i[i]) free_c = BUF_SEL_W'(i);
    end
  end

endmodule

// File: rtl/vdma_wbuf_scheduler.sv
// Four-buffer frame scheduler: steers the write core's shadow address, tracks the
// newest complete frame and protects the buffer held by the reader.
module vdma_wbuf_scheduler
  import vdma_wbuf_scheduler_pkg::*;
#(
  parameter int unsigned AXI4_ADDR_WIDTH = 32,
  parameter int unsigned INDEX_WIDTH     = 8,
  parameter int unsigned FCNT_WIDTH      = 16
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       cfg_enable,
  input  logic [AXI4_ADDR_WIDTH-1:0] cfg_addr0,
  input  logic [AXI4_ADDR_WIDTH-1:0] cfg_addr1,
  input  logic [AXI4_ADDR_WIDTH-1:0] cfg_addr2,
  input  logic [AXI4_ADDR_WIDTH-1:0] cfg_addr3,
  vdma_wbuf_scheduler_if.master      bus,
  output buf_sel_t                   st_write,
  output buf_sel_t                   st_latest,
  output logic [FCNT_WIDTH-1:0]      st_frame_count
);

  state_e                 state_q, state_d;
  logic                   en_q, en_d;
  buf_sel_t               cur_q, cur_d, nxt_q, nxt_d, latest_q, latest_d, rd_q, rd_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;
  logic [FCNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                   done_q, done_d;
  logic                   acc_q, acc_d;

  logic                       idx_chg;
  buf_sel_t                   cur_n, latest_n;
  logic [FCNT_WIDTH-1:0]      cnt_n;
  logic                       done_n;
  logic [NUM_BUFS-1:0]        excl_c;
  buf_sel_t                   free_c;
  logic [AXI4_ADDR_WIDTH-1:0] cfg_addr_c [NUM_BUFS];

  assign cfg_addr_c[0] = cfg_addr0;
  assign cfg_addr_c[1] = cfg_addr1;
  assign cfg_addr_c[2] = cfg_addr2;
  assign cfg_addr_c[3] = cfg_addr3;

  // Role updates for this cycle; acc_q separates the first acceptance from a completion.
  always_comb begin
    idx_chg    = (state_q != ST_IDLE) && (bus.core_ctl_index != idx_q);
    rd_d       = rd_q;
    rd_valid_d = rd_valid_q;
    if (bus.rd_req && done_q) begin
      rd_d       = latest_q;
      rd_valid_d = 1'b1;
    end
    cur_n    = cur_q;
    latest_n = latest_q;
    cnt_n    = cnt_q;
    done_n   = done_q;
    if (idx_chg && acc_q) begin
      latest_n = cur_q;
      cur_n    = nxt_q;
      cnt_n    = cnt_n + FCNT_WIDTH'(1);
      done_n   = 1'b1;
    end
    if (state_q == ST_STOP && !bus.core_ctl_busy && (acc_q || idx_chg)) begin
      latest_n = cur_n;
      cnt_n    = cnt_n + FCNT_WIDTH'(1);
      done_n   = 1'b1;
    end
    excl_c = '0;
    if (rd_valid_d)          excl_c = excl_c | buf_bit(rd_d);
    if (done_n)              excl_c = excl_c | buf_bit(latest_n);
    if (state_q != ST_IDLE)  excl_c = excl_c | buf_bit(cur_n);
  end

  vdma_wbuf_free_sel u_free_sel (
    .excl_i (excl_c),
    .free_c (free_c)
  );

  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    cur_d    = cur_n;
    nxt_d    = nxt_q;
    latest_d = latest_n;
    cnt_d    = cnt_n;
    done_d   = done_n;
    idx_d    = idx_q;
    acc_d    = acc_q;
    if (idx_chg) begin
      idx_d = bus.core_ctl_index;
      nxt_d = free_c;
      acc_d = 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        en_d = 1'b0;
        if (cfg_enable && !bus.core_ctl_busy) begin
          cur_d   = free_c;
          nxt_d   = free_c;
          idx_d   = bus.core_ctl_index;
          acc_d   = 1'b0;
          en_d    = 1'b1;
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        if (idx_chg) state_d = ST_RUN;
        if (!cfg_enable) begin
          en_d    = 1'b0;
          state_d = ST_STOP;
        end
      end
      ST_RUN: begin
        if (!cfg_enable) begin
          en_d    = 1'b0;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        en_d = 1'b0;
        if (!bus.core_ctl_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= ST_IDLE;
      en_q       <= 1'b0;
      cur_q      <= '0;
      nxt_q      <= '0;
      latest_q   <= '0;
      rd_q       <= '0;
      rd_valid_q <= 1'b0;
      idx_q      <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      acc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      cur_q      <= cur_d;
      nxt_q      <= nxt_d;
      latest_q   <= latest_d;
      rd_q       <= rd_d;
      rd_valid_q <= rd_valid_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      acc_q      <= acc_d;
    end
  end

  // Shadow address is only meaningful once the core is armed.
  assign bus.core_param_addr = (state_q == ST_IDLE) ? '0 : cfg_addr_c[nxt_q];
  assign bus.core_ctl_enable = en_q;
  assign bus.core_ctl_update = en_q;
  assign bus.rd_valid        = rd_valid_q;
  assign bus.rd_sel          = rd_q;
  assign bus.rd_addr         = cfg_addr_c[rd_q];
  assign st_write            = cur_q;
  assign st_latest           = latest_q;
  assign st_frame_count      = cnt_q;

endmodule

// File: tb/tb_vdma_wbuf_scheduler.sv
// Directed bench for the write-buffer scheduler with a queue of expected per-frame results.
module tb_vdma_wbuf_scheduler;
  import vdma_wbuf_scheduler_pkg::*;

  localparam logic [31:0] A0 = 32'h1000_0000;
  localparam logic [31:0] A1 = 32'h2000_0000;
  localparam logic [31:0] A2 = 32'h3000_0000;
  localparam logic [31:0] A3 = 32'h4000_0000;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  wr;
    logic [1:0]  lat;
    logic [15:0] cnt;
  } exp_t;

  logic        aclk;
  logic        areset;
  logic        cfg_enable;
  logic [31:0] cfg_addr0, cfg_addr1, cfg_addr2, cfg_addr3;
  buf_sel_t    st_write, st_latest;
  logic [15:0] st_frame_count;
  int          checks;
  int          errors;
  exp_t        exp_q[$];

  vdma_wbuf_scheduler_if #(.AXI4_ADDR_WIDTH(32), .INDEX_WIDTH(8)) bus ();

  vdma_wbuf_scheduler #(.AXI4_ADDR_WIDTH(32), .INDEX_WIDTH(8), .FCNT_WIDTH(16)) dut (
    .aclk           (aclk),
    .areset         (areset),
    .cfg_enable     (cfg_enable),
    .cfg_addr0      (cfg_addr0),
    .cfg_addr1      (cfg_addr1),
    .cfg_addr2      (cfg_addr2),
    .cfg_addr3      (cfg_addr3),
    .bus            (bus),
    .st_write       (st_write),
    .st_latest      (st_latest),
    .st_frame_count (st_frame_count)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Core accepts or completes a frame: index moves, expected roles come off the queue.
  task automatic frame_step(input logic [7:0] idx, input logic rq, input logic [31:0] a,
                            input logic [1:0] w, input logic [1:0] l, input logic [15:0] c);
    exp_t e;
    e.addr = a;
    e.wr   = w;
    e.lat  = l;
    e.cnt  = c;
    exp_q.push_back(e);
    bus.core_ctl_index = idx;
    bus.rd_req         = rq;
    tick();
    bus.rd_req = 1'b0;
    e = exp_q.pop_front();
    chk("param_addr", bus.core_param_addr, e.addr);
    chk("st_write", 32'(st_write), 32'(e.wr));
    chk("st_latest", 32'(st_latest), 32'(e.lat));
    chk("frame_count", 32'(st_frame_count), 32'(e.cnt));
  endtask

  initial begin
    checks             = 0;
    errors             = 0;
    areset             = 1'b1;
    cfg_enable         = 1'b0;
    cfg_addr0          = A0;
    cfg_addr1          = A1;
    cfg_addr2          = A2;
    cfg_addr3          = A3;
    bus.core_ctl_busy  = 1'b0;
    bus.core_ctl_index = 8'h00;
    bus.rd_req         = 1'b0;
    repeat (2) tick();

    chk("rst_enable", 32'(bus.core_ctl_enable), 32'd0);
    chk("rst_update", 32'(bus.core_ctl_update), 32'd0);
    chk("rst_param", bus.core_param_addr, 32'd0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_write", 32'(st_write), 32'd0);
    chk("rst_count", 32'(st_frame_count), 32'd0);
    areset = 1'b0;

    // Free-running writes with no reader.
    cfg_enable = 1'b1;
    tick();
    chk("arm_enable", 32'(bus.core_ctl_enable), 32'd1);
    chk("arm_update", 32'(bus.core_ctl_update), 32'd1);
    chk("arm_param", bus.core_param_addr, A0);
    bus.core_ctl_busy = 1'b1;
    frame_step(8'h01, 1'b0, A1, 2'd0, 2'd0, 16'd0);
    frame_step(8'h02, 1'b0, A2, 2'd1, 2'd0, 16'd1);
    frame_step(8'h03, 1'b0, A0, 2'd2, 2'd1, 16'd2);
    frame_step(8'h04, 1'b0, A1, 2'd0, 2'd2, 16'd3);

    // Asynchronous reset mid-RUN, observed before any clock edge.
    #2;
    areset = 1'b1;
    #1;
    chk("async_enable", 32'(bus.core_ctl_enable), 32'd0);
    chk("async_update", 32'(bus.core_ctl_update), 32'd0);
    chk("async_param", bus.core_param_addr, 32'd0);
    chk("async_count", 32'(st_frame_count), 32'd0);
    chk("async_latest", 32'(st_latest), 32'd0);
    bus.core_ctl_busy  = 1'b0;
    bus.core_ctl_index = 8'h00;
    tick();
    areset = 1'b0;

    tick();
    chk("rearm_param", bus.core_param_addr, A0);
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    chk("early_rd_valid", 32'(bus.rd_valid), 32'd0);

    bus.core_ctl_busy = 1'b1;
    frame_step(8'h01, 1'b0, A1, 2'd0, 2'd0, 16'd0);
    frame_step(8'h02, 1'b0, A2, 2'd1, 2'd0, 16'd1);

    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    chk("rd_valid", 32'(bus.rd_valid), 32'd1);
    chk("rd_sel", 32'(bus.rd_sel), 32'd0);
    chk("rd_addr", bus.rd_addr, A0);

    frame_step(8'h03, 1'b0, A3, 2'd2, 2'd1, 16'd2);
    frame_step(8'h04, 1'b1, A0, 2'd3, 2'd2, 16'd3);
    chk("rd_sel_coincide", 32'(bus.rd_sel), 32'd1);
    frame_step(8'h05, 1'b0, A2, 2'd0, 2'd3, 16'd4);

    // Stop request while the core is still writing.
    cfg_enable = 1'b0;
    tick();
    chk("stop_enable", 32'(bus.core_ctl_enable), 32'd0);
    chk("stop_update", 32'(bus.core_ctl_update), 32'd0);
    tick();
    chk("stop_wait_count", 32'(st_frame_count), 32'd4);
    bus.core_ctl_busy = 1'b0;
    tick();
    chk("stop_latest", 32'(st_latest), 32'd0);
    chk("stop_count", 32'(st_frame_count), 32'd5);
    chk("idle_param", bus.core_param_addr, 32'd0);

    // Restart near the top of the index range, then wrap and skip.
    bus.core_ctl_index = 8'hFE;
    cfg_enable         = 1'b1;
    tick();
    chk("restart_write", 32'(st_write), 32'd2);
    chk("restart_param", bus.core_param_addr, A2);
    bus.core_ctl_busy = 1'b1;
    frame_step(8'hFF, 1'b0, A3, 2'd2, 2'd0, 16'd5);
    frame_step(8'h00, 1'b0, A0, 2'd3, 2'd2, 16'd6);
    frame_step(8'h02, 1'b0, A2, 2'd0, 2'd3, 16'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
